// File: rtl/com_bus_arbiter_4.sv
// rtl/com_bus_arbiter_4.sv - four-core common-bus arbiter with round-robin proc/snoop grants
// A snoop grant may nest inside a live processor grant; every tenure ends with one all-idle RELEASE cycle.
module com_bus_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Com_Bus_Req_proc,
  input  logic [3:0] Com_Bus_Req_snoop,
  output logic [3:0] Com_Bus_Gnt_proc,
  output logic [3:0] Com_Bus_Gnt_snoop,
  output logic       Bus_busy,
  output logic [1:0] Gnt_owner,
  output logic       Hold_timeout
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GNT_PROC  = 3'd1,
    GNT_SNOOP = 3'd2,
    GNT_NEST  = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  localparam logic [7:0] L_MAX_HOLD = 8'(MAX_HOLD);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_gnt_proc, w_gnt_proc_nxt;
  logic [3:0] r_gnt_snoop, w_gnt_snoop_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_snoop_idx, w_snoop_idx_nxt;
  logic [1:0] r_rr, w_rr_nxt;
  logic       r_nested, w_nested_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic       r_busy;
  logic       w_new_proc;
  logic [2:0] w_pick_proc, w_pick_snoop, w_pick_nest;
  logic       w_own_req, w_snp_req;

  // Returns {found, index}; search order rr+1, rr+2, rr+3, rr, so the
  // highest-priority candidate is written last and wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] rr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = rr + 2'(k);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    w_pick_proc  = rr_pick(Com_Bus_Req_proc, r_rr);
    w_pick_snoop = rr_pick(Com_Bus_Req_snoop, r_rr);
    w_pick_nest  = rr_pick(Com_Bus_Req_snoop & ~(4'b0001 << r_owner), r_rr);
    w_own_req    = Com_Bus_Req_proc[r_owner];
    w_snp_req    = Com_Bus_Req_snoop[r_snoop_idx];
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_proc_nxt  = r_gnt_proc;
    w_gnt_snoop_nxt = r_gnt_snoop;
    w_owner_nxt     = r_owner;
    w_snoop_idx_nxt = r_snoop_idx;
    w_rr_nxt        = r_rr;
    w_nested_nxt    = r_nested;
    w_new_proc      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_snoop[2]) begin
          w_state_nxt     = GNT_SNOOP;
          w_gnt_snoop_nxt = 4'b0001 << w_pick_snoop[1:0];
          w_snoop_idx_nxt = w_pick_snoop[1:0];
          w_nested_nxt    = 1'b0;
        end else if (w_pick_proc[2]) begin
          w_state_nxt    = GNT_PROC;
          w_gnt_proc_nxt = 4'b0001 << w_pick_proc[1:0];
          w_owner_nxt    = w_pick_proc[1:0];
          w_new_proc     = 1'b1;
        end
      end
      GNT_PROC: begin
        if (!w_own_req) begin
          w_state_nxt    = RELEASE;
          w_gnt_proc_nxt = 4'b0000;
          w_rr_nxt       = r_owner;
        end else if (w_pick_nest[2]) begin
          w_state_nxt     = GNT_NEST;
          w_gnt_snoop_nxt = 4'b0001 << w_pick_nest[1:0];
          w_snoop_idx_nxt = w_pick_nest[1:0];
        end
      end
      GNT_NEST: begin
        if (!w_own_req && !w_snp_req) begin
          w_state_nxt     = RELEASE;
          w_gnt_proc_nxt  = 4'b0000;
          w_gnt_snoop_nxt = 4'b0000;
          w_rr_nxt        = r_owner;
        end else if (!w_snp_req) begin
          w_state_nxt     = GNT_PROC;
          w_gnt_snoop_nxt = 4'b0000;
        end else if (!w_own_req) begin
          // Snoop tenure continues alone; remember the proc owner for rr.
          w_state_nxt    = GNT_SNOOP;
          w_gnt_proc_nxt = 4'b0000;
          w_nested_nxt   = 1'b1;
        end
      end
      GNT_SNOOP: begin
        if (!w_snp_req) begin
          w_state_nxt     = RELEASE;
          w_gnt_snoop_nxt = 4'b0000;
          w_rr_nxt        = r_nested ? r_owner : r_snoop_idx;
        end
      end
      RELEASE: begin
        w_state_nxt     = IDLE;
        w_gnt_proc_nxt  = 4'b0000;
        w_gnt_snoop_nxt = 4'b0000;
        w_nested_nxt    = 1'b0;
      end
      default: begin
        w_state_nxt     = IDLE;
        w_gnt_proc_nxt  = 4'b0000;
        w_gnt_snoop_nxt = 4'b0000;
      end
    endcase
  end

  // r_hold equals the number of grant cycles seen so far, including the current one.
  always_comb begin
    w_hold_nxt = r_hold;
    if (w_new_proc) begin
      w_hold_nxt = 8'd1;
    end else if ((|w_gnt_proc_nxt) && (r_hold < L_MAX_HOLD)) begin
      w_hold_nxt = r_hold + 8'd1;
    end
    w_timeout_nxt = (|w_gnt_proc_nxt) && (w_hold_nxt == L_MAX_HOLD) && (r_hold != L_MAX_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt_proc  <= 4'b0000;
      r_gnt_snoop <= 4'b0000;
      r_owner     <= 2'd0;
      r_snoop_idx <= 2'd0;
      r_rr        <= 2'd3;
      r_nested    <= 1'b0;
      r_hold      <= 8'd0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_proc  <= w_gnt_proc_nxt;
      r_gnt_snoop <= w_gnt_snoop_nxt;
      r_owner     <= w_owner_nxt;
      r_snoop_idx <= w_snoop_idx_nxt;
      r_rr        <= w_rr_nxt;
      r_nested    <= w_nested_nxt;
      r_hold      <= w_hold_nxt;
      r_timeout   <= w_timeout_nxt;
      r_busy      <= (|w_gnt_proc_nxt) || (|w_gnt_snoop_nxt);
    end
  end

  assign Com_Bus_Gnt_proc  = r_gnt_proc;
  assign Com_Bus_Gnt_snoop = r_gnt_snoop;
  assign Bus_busy          = r_busy;
  assign Gnt_owner         = r_owner;
  assign Hold_timeout      = r_timeout;

endmodule

// File: tb/tb_com_bus_arbiter_4.sv
// tb/tb_com_bus_arbiter_4.sv - directed self-checking bench for com_bus_arbiter_4
module tb_com_bus_arbiter_4;

  logic       clk;
  logic       rst;
  logic [3:0] req_proc;
  logic [3:0] req_snoop;
  logic [3:0] gnt_proc;
  logic [3:0] gnt_snoop;
  logic       busy;
  logic [1:0] owner;
  logic       timeout;

  int checks;
  int failures;

  com_bus_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .Com_Bus_Req_proc  (req_proc),
    .Com_Bus_Req_snoop (req_snoop),
    .Com_Bus_Gnt_proc  (gnt_proc),
    .Com_Bus_Gnt_snoop (gnt_snoop),
    .Bus_busy          (busy),
    .Gnt_owner         (owner),
    .Hold_timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_proc  = 4'b0000;
    req_snoop = 4'b0000;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req_proc  = 4'b0000;
    req_snoop = 4'b0000;
    rst       = 1'b1;
    #2;
    checks++;
    if ({gnt_proc, gnt_snoop, busy, owner, timeout} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 000", {gnt_proc, gnt_snoop, busy, owner, timeout});
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_first_grant();
    do_reset();
    req_proc = 4'b1010;
    tick();
    checks++;
    if (gnt_proc !== 4'b0010 || owner !== 2'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL first_grant: gnt=%b owner=%0d busy=%b want 0010 1 1", gnt_proc, owner, busy);
    end
    req_proc = 4'b0000;
    tick();
    checks++;
    if (gnt_proc !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL first_release: gnt=%b busy=%b want 0000 0", gnt_proc, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [5];
    exp_gnt[0] = 4'b0001; exp_gnt[1] = 4'b0010; exp_gnt[2] = 4'b0100;
    exp_gnt[3] = 4'b1000; exp_gnt[4] = 4'b0001;
    do_reset();
    req_proc = 4'b1111;
    tick();
    for (int g = 0; g < 5; g++) begin
      checks++;
      if (gnt_proc !== exp_gnt[g] || owner !== 2'(g % 4)) begin
        failures++;
        $display("FAIL rr_grant%0d: gnt=%b owner=%0d want %b %0d", g, gnt_proc, owner, exp_gnt[g], g % 4);
      end
      req_proc = 4'b1111 & ~exp_gnt[g];
      tick();
      checks++;
      if (gnt_proc !== 4'b0000 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rr_release%0d: gnt=%b busy=%b want 0000 0", g, gnt_proc, busy);
      end
      req_proc = 4'b1111;
      tick();
      tick();
    end
    req_proc = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_nest();
    do_reset();
    req_proc = 4'b0100;
    tick();
    req_snoop = 4'b0100;
    tick();
    checks++;
    if (gnt_snoop !== 4'b0000 || gnt_proc !== 4'b0100) begin
      failures++;
      $display("FAIL nest_own_snoop: snoop=%b proc=%b want 0000 0100", gnt_snoop, gnt_proc);
    end
    req_snoop = 4'b0001;
    tick();
    checks++;
    if (gnt_snoop !== 4'b0001 || gnt_proc !== 4'b0100 || owner !== 2'd2) begin
      failures++;
      $display("FAIL nest_grant: snoop=%b proc=%b owner=%0d want 0001 0100 2", gnt_snoop, gnt_proc, owner);
    end
    req_snoop = 4'b0000;
    tick();
    checks++;
    if (gnt_snoop !== 4'b0000 || gnt_proc !== 4'b0100) begin
      failures++;
      $display("FAIL nest_return: snoop=%b proc=%b want 0000 0100", gnt_snoop, gnt_proc);
    end
    req_proc = 4'b0000;
    tick();
    checks++;
    if (gnt_proc !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nest_release: proc=%b busy=%b want 0000 0", gnt_proc, busy);
    end
  endtask

  task automatic test_nest_proc_first();
    do_reset();
    req_proc = 4'b0001;
    tick();
    req_snoop = 4'b0010;
    tick();
    req_proc = 4'b0000;
    tick();
    checks++;
    if (gnt_proc !== 4'b0000 || gnt_snoop !== 4'b0010 || busy !== 1'b1) begin
      failures++;
      $display("FAIL nest_proc_drop: proc=%b snoop=%b busy=%b want 0000 0010 1", gnt_proc, gnt_snoop, busy);
    end
    req_snoop = 4'b0000;
    tick();
    checks++;
    if (gnt_snoop !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL nest_snoop_drop: snoop=%b busy=%b want 0000 0", gnt_snoop, busy);
    end
    req_proc = 4'b0011;
    tick();
    tick();
    checks++;
    if (gnt_proc !== 4'b0010 || owner !== 2'd1) begin
      failures++;
      $display("FAIL rr_after_nest: proc=%b owner=%0d want 0010 1", gnt_proc, owner);
    end
    req_proc = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_snoop_priority();
    do_reset();
    req_proc  = 4'b0001;
    req_snoop = 4'b1000;
    tick();
    checks++;
    if (gnt_snoop !== 4'b1000 || gnt_proc !== 4'b0000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL snoop_priority: snoop=%b proc=%b busy=%b want 1000 0000 1", gnt_snoop, gnt_proc, busy);
    end
  endtask

  task automatic test_same_drop();
    do_reset();
    req_proc = 4'b0001;
    tick();
    req_snoop = 4'b0100;
    tick();
    req_proc  = 4'b0000;
    req_snoop = 4'b0000;
    tick();
    checks++;
    if (gnt_proc !== 4'b0000 || gnt_snoop !== 4'b0000 || busy !== 1'b0) begin
      failures++;
      $display("FAIL same_drop: proc=%b snoop=%b busy=%b want 0000 0000 0", gnt_proc, gnt_snoop, busy);
    end
  endtask

  task automatic test_short_request();
    do_reset();
    req_proc = 4'b0100;
    tick();
    req_proc = 4'b0000;
    checks++;
    if (gnt_proc !== 4'b0100) begin
      failures++;
      $display("FAIL short_grant: proc=%b want 0100", gnt_proc);
    end
    tick();
    checks++;
    if (gnt_proc !== 4'b0000) begin
      failures++;
      $display("FAIL short_release: proc=%b want 0000", gnt_proc);
    end
  endtask

  task automatic test_hold_timeout();
    int pulses;
    pulses = 0;
    do_reset();
    req_proc = 4'b1000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (timeout === 1'b1) pulses++;
      checks++;
      if (gnt_proc !== 4'b1000 || timeout !== (k == 4)) begin
        failures++;
        $display("FAIL hold_cycle%0d: proc=%b timeout=%b want 1000 %b", k, gnt_proc, timeout, (k == 4));
      end
    end
    checks++;
    if (pulses != 1) begin
      failures++;
      $display("FAIL hold_pulses: got %0d want 1", pulses);
    end
    req_proc = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_proc = 4'b0001;
    tick();
    req_snoop = 4'b0010;
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt_proc, gnt_snoop, busy, owner, timeout} !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid: got %h want 000", {gnt_proc, gnt_snoop, busy, owner, timeout});
    end
    req_proc  = 4'b1111;
    req_snoop = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (gnt_proc !== 4'b0001 || owner !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_regrant: proc=%b owner=%0d want 0001 0", gnt_proc, owner);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst       = 1'b1;
    req_proc  = 4'b0000;
    req_snoop = 4'b0000;
    test_reset();
    test_first_grant();
    test_round_robin();
    test_nest();
    test_nest_proc_first();
    test_snoop_priority();
    test_same_drop();
    test_short_request();
    test_hold_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/com_bus_arbiter_4.md
COM_BUS_ARBITER_4 -- requirements
Module: com_bus_arbiter_4

Interface
REQ-001 Parameter: MAX_HOLD, 64, cycles a processor grant may be held before Hold_timeout pulses (range 2..255).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 Com_Bus_Req_proc  input  4  per-core request for the common bus as master (bit i = core i).
REQ-005 Com_Bus_Req_snoop  input  4  per-core request to drive the common bus as snoop responder.
REQ-006 Com_Bus_Gnt_proc  output  4  per-core master grant, registered, at most one bit set.
REQ-007 Com_Bus_Gnt_snoop  output  4  per-core snoop grant, registered, at most one bit set.
REQ-008 Bus_busy  output  1  registered; 1 whenever any grant bit is set.
REQ-009 Gnt_owner  output  2  registered index of current processor-grant owner; holds last owner when idle.
REQ-010 Hold_timeout  output  1  registered one-cycle pulse when a processor grant reaches MAX_HOLD cycles.

Function
REQ-011 FSM states SHALL be IDLE, GNT_PROC, GNT_SNOOP, GNT_NEST, RELEASE; encoding free.
REQ-012 Round-robin pointer rr (2 bits) SHALL define search order rr+1, rr+2, rr+3, rr (mod 4) for both request classes.
REQ-013 IDLE: any Req_snoop set -> GNT_SNOOP, grant first snoop requester in rr order; else any Req_proc set -> GNT_PROC, grant first proc requester in rr order; else stay.
REQ-014 Grant latency SHALL be exactly one cycle: request sampled high in IDLE at edge N, grant visible after edge N.
REQ-015 Snoop requests SHALL take precedence over processor requests when both present in IDLE.
REQ-016 GNT_PROC: grant held while owner keeps Req_proc high; other cores' Req_proc ignored.
REQ-017 GNT_PROC: Req_snoop from core j != owner -> GNT_NEST, Gnt_snoop[j] asserted next cycle, Gnt_proc[owner] unchanged; owner's own Req_snoop ignored.
REQ-018 GNT_NEST: Gnt_snoop[j] dropped one cycle after Req_snoop[j] falls, return to GNT_PROC; if owner drops Req_proc first, Gnt_proc[owner] drops next cycle, FSM moves to GNT_SNOOP keeping Gnt_snoop[j].
REQ-019 GNT_NEST with both owner Req_proc and Req_snoop[j] falling same cycle -> both grants drop next cycle, go RELEASE.
REQ-020 GNT_PROC: owner drops Req_proc -> RELEASE, Gnt_proc cleared next cycle.
REQ-021 GNT_SNOOP: grant held while Req_snoop[j] high; on drop -> RELEASE.
REQ-022 RELEASE SHALL last exactly one cycle with all grants 0, then IDLE; no request evaluated during RELEASE.
REQ-023 rr SHALL update to the released processor owner index on entry to RELEASE after any processor grant; snoop-only grants set rr to the snoop owner.
REQ-024 Hold counter (8 bits) SHALL clear on each new processor grant, increment each cycle Gnt_proc nonzero, saturate at MAX_HOLD; Hold_timeout pulses on the cycle count reaches MAX_HOLD; grant is not revoked.
REQ-025 A requester dropping its request before its grant appears SHALL still receive a one-cycle grant, then normal release.
REQ-026 Gnt_owner SHALL update in same cycle as Gnt_proc assertion.

Reset
REQ-027 rst high SHALL force immediately: state IDLE, all grants 0, Bus_busy 0, Hold_timeout 0, Gnt_owner 0, rr 3, hold counter 0.
REQ-028 Reset asserted mid-grant SHALL drop grants asynchronously; first grant after release uses rr 3 (core 0 first).

Verification
REQ-029 After reset, Req_proc=4'b1010 at edge 1 -> Gnt_proc=4'b0010 after edge 1, Gnt_owner=1, Bus_busy=1.
REQ-030 Req_proc=4'b1111 held, each owner drops for one cycle after grant -> grant order 0,1,2,3,0 with one RELEASE cycle between grants.
REQ-031 Core 2 owns proc grant, Req_snoop=4'b0001 -> Gnt_snoop=4'b0001 next cycle, Gnt_proc=4'b0100 held; Req_snoop[2] alone -> no snoop grant.
REQ-032 IDLE with Req_proc=4'b0001 and Req_snoop=4'b1000 same cycle -> Gnt_snoop=4'b1000, Gnt_proc=0.
REQ-033 MAX_HOLD=4, core 3 holds Req_proc 10 cycles -> Hold_timeout single pulse on 4th grant cycle, Gnt_proc=4'b1000 retained throughout.
REQ-034 rst pulsed during GNT_NEST -> all outputs 0 before next clock edge, next Req_proc=4'b1111 grants core 0.
